bus_arbiter_mux: RTL

- Parametrised, registered N-source bus multiplexer. It drives the shared datapath bus and replaces the fixed-width, fixed-count select mux.
- Two source-selection modes:
  - Direct: an encoded select, as used by the control unit.
  - Arbitrated: round-robin arbitration among requesting sources, with bounded bus locking.
- All outputs are registered on clk. One cycle of latency from sampled inputs to bus.

---
 rtl/bus_arbiter_mux_if.sv | 39 +++
 rtl/bus_arbiter_mux.sv | 109 ++++++++++
 2 files changed

// File: rtl/bus_arbiter_mux_if.sv
// Bus-side signal bundle for bus_arbiter_mux. The slave modport is the mux side.
// BUS_ARB_PARITY_EN adds the bus_parity output.
interface bus_arbiter_mux_if #(
  parameter int NUM_SRC = 24,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 5
);
  logic [NUM_SRC*DATA_W-1:0] data_in;
  logic                      sel_en;
  logic [SEL_W-1:0]          sel;
  logic [NUM_SRC-1:0]        req;
  logic                      lock;
  logic [DATA_W-1:0]         bus_contents;
  logic                      bus_valid;
  logic [NUM_SRC-1:0]        grant;
  logic [SEL_W-1:0]          grant_idx;
  logic                      sel_err;
`ifdef BUS_ARB_PARITY_EN
  logic                      bus_parity;

  modport slave (
    input  data_in, sel_en, sel, req, lock,
    output bus_contents, bus_valid, grant, grant_idx, sel_err, bus_parity
  );
  modport master (
    output data_in, sel_en, sel, req, lock,
    input  bus_contents, bus_valid, grant, grant_idx, sel_err, bus_parity
  );
`else
  modport slave (
    input  data_in, sel_en, sel, req, lock,
    output bus_contents, bus_valid, grant, grant_idx, sel_err
  );
  modport master (
    output data_in, sel_en, sel, req, lock,
    input  bus_contents, bus_valid, grant, grant_idx, sel_err
  );
`endif
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered N-source bus mux: direct encoded select or round-robin arbitration with bounded lock.
// Optional feature macro: BUS_ARB_PARITY_EN (adds registered bus_parity).
module bus_arbiter_mux #(
  parameter int NUM_SRC  = 24,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 4
) (
  input logic              clk,
  input logic              clr,
  bus_arbiter_mux_if.slave bus
);
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int HC_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [NUM_SRC-1:0][DATA_W-1:0] src;
  assign src = bus.data_in;

  logic [DATA_W-1:0]  bus_q;
  logic               vld_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [SEL_W-1:0]   gidx;
  logic               err_q;
  logic [PTR_W-1:0]   ptr;
  logic [HC_W-1:0]    hold_cnt;
  logic               arb_vld;   // last cycle was a valid arbitrated grant, so lock may continue

  logic               sel_ok, lock_ok, rr_hit, ld_en, ld_lock;
  logic [PTR_W-1:0]   rr_idx;
  logic [SEL_W-1:0]   ld_idx;

  assign sel_ok  = int'(bus.sel) < NUM_SRC;
  assign lock_ok = arb_vld && bus.req[gidx] && bus.lock && (int'(hold_cnt) < MAX_HOLD-1);

  // Walk down from the farthest candidate so the nearest requester past ptr wins.
  always_comb begin : rr_search
    int j;
    j      = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (bus.req[PTR_W'(j)]) begin
        rr_hit = 1'b1;
        rr_idx = PTR_W'(j);
      end
    end
  end

  always_comb begin
    ld_en   = 1'b0;
    ld_lock = 1'b0;
    ld_idx  = '0;
    if (bus.sel_en) begin
      if (sel_ok) begin
        ld_en  = 1'b1;
        ld_idx = bus.sel;
      end
    end else if (lock_ok) begin
      ld_en   = 1'b1;
      ld_lock = 1'b1;
      ld_idx  = gidx;
    end else if (rr_hit) begin
      ld_en  = 1'b1;
      ld_idx = SEL_W'(rr_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      bus_q    <= '0;
      vld_q    <= 1'b0;
      grant_q  <= '0;
      gidx     <= '0;
      err_q    <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
      arb_vld  <= 1'b0;
    end else begin
      err_q    <= bus.sel_en && !sel_ok;
      vld_q    <= ld_en;
      grant_q  <= ld_en ? (NUM_SRC'(1) << ld_idx) : '0;
      arb_vld  <= ld_en && !bus.sel_en;
      hold_cnt <= ld_lock ? hold_cnt + 1'b1 : '0;
      if (ld_en) begin
        bus_q <= src[ld_idx];
        gidx  <= ld_idx;
      end
      if (!bus.sel_en && !ld_lock && rr_hit)
        ptr <= (int'(rr_idx) == NUM_SRC-1) ? '0 : rr_idx + 1'b1;
    end
  end

  assign bus.bus_contents = bus_q;
  assign bus.bus_valid    = vld_q;
  assign bus.grant        = grant_q;
  assign bus.grant_idx    = gidx;
  assign bus.sel_err      = err_q;

`ifdef BUS_ARB_PARITY_EN
  logic par_q;
  always_ff @(posedge clk) begin
    if (clr)        par_q <= 1'b0;
    else if (ld_en) par_q <= ^src[ld_idx];
  end
  assign bus.bus_parity = par_q;
`endif
endmodule
